wb_merge: RTL
=============

# wb_merge

Write-back merge unit for the pipelined CPU. It feeds the single register-file write port from two producers. The in-order W-stage result always wins the port. Results from multi-cycle units (mult/div and similar) are held in a DEPTH-entry FIFO and retired in cycles where W does not write. The unit also kills stale buffered results that W has overwritten, and offers a forwarding lookup into the buffer.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- DEPTH, 4, side-result FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock; the only clock
- reset  in  1  synchronous, active-high
- w_valid  in  1  W stage requests a register write this cycle
- w_adr  in  ADDR_W  W destination register
- w_data  in  DATA_W  W write data
- w_pc  in  32  W instruction PC (trace only)
- s_valid  in  1  side unit offers a result
- s_ready  out  1  FIFO can accept; equals count < DEPTH
- s_adr  in  ADDR_W  side destination register
- s_data  in  DATA_W  side result
- s_pc  in  32  PC of originating instruction (trace only)
- regw_enable  out  1  register-file write enable (registered)
- regw_adr  out  ADDR_W  register-file write address (registered)
- reg_write  out  DATA_W  register-file write data (registered)
- fwd_adr  in  ADDR_W  forwarding lookup address
- fwd_hit  out  1  live FIFO entry matches fwd_adr
- fwd_data  out  DATA_W  data of youngest live match; 0 when no hit
- count  out  $clog2(DEPTH)+1  occupied FIFO entries, killed entries included

## Operation
- The side handshake completes when s_valid && s_ready. The entry {adr, data, pc, live=1} is pushed at the tail.
- Port arbitration, per cycle:
  - If w_valid && w_adr != 0, the W write is selected.
  - Otherwise, if the FIFO is non-empty, the head is popped.
    - A live head with adr != 0 is selected.
    - A killed head, or one with adr 0, is popped with no write.
  - Otherwise there is no write.
- Selected write goes to the output registers on the next edge. With no write, regw_enable=0, and regw_adr and reg_write are 0.
- W writes with w_adr == 0 are discarded. They count as idle, so the FIFO may drain in that cycle.
- Kill rule: when W writes adr A != 0, every entry stored before this edge with adr A has live cleared. An entry pushed in the same cycle is not killed; it is treated as younger.
- Forwarding is combinational over live entries only.
  - Youngest match wins.
  - fwd_adr == 0 never hits.
  - The output register is not searched.
- Push and pop in the same cycle are allowed. count is unchanged, and head/tail wrap modulo DEPTH.
- A push when full cannot occur: s_ready=0. s_valid without s_ready has no effect.
- Reset: FIFO emptied, count=0, all live bits cleared, regw_enable=0, regw_adr=0, reg_write=0, s_ready=1. Reset mid-drain discards all buffered results without writing.

## Timing
- W path latency: request in cycle N, regw_* valid in cycle N+1.
- Side path minimum latency: accepted in cycle N, popped at earliest in cycle N+1, regw_* valid in cycle N+2.
- s_ready depends only on registered count; there is no combinational path from s_valid.
- fwd_hit and fwd_data are combinational from fwd_adr and FIFO state.
- Continuous W writes starve the FIFO indefinitely. The stall unit must guarantee idle W slots; this block provides no fairness.

## Configuration
- WB_MERGE_TRACE_EN defined: on every clk edge where a write is registered, the unit emits one $display line "@%h: $%d <= %h" using the winning PC, address and data, with the address printed in decimal. Killed and $0 pops print nothing.
- WB_MERGE_TRACE_EN undefined: no display statements compiled; behaviour otherwise identical.

## Test plan
- Reset, then W writes $3=0x11 at PC 0x3000 -> next cycle regw_enable=1, regw_adr=3, reg_write=0x11; cycle after, regw_enable=0.
- Side pushes $8=0xAA while w_valid=0 -> s_ready=1; two cycles later regw_adr=8, reg_write=0xAA; count returns to 0.
- Push four side results with W writing $1 every cycle -> count=4, s_ready=0, fwd_adr=$9 hits youngest entry. Drop w_valid -> four writes retire in FIFO order on consecutive cycles.
- Buffer $5=0x1, then W writes $5=0x2 -> next cycle writes 0x2; fwd_hit for $5 now 0; the later pop of $5 produces no write; the final value is 0x2.
- Same-cycle W write $7 and side push $7=0x9 -> the pushed entry stays live and later writes 0x9.
- Reset asserted with count=3 -> next cycle count=0, regw_enable=0, s_ready=1, and no buffered write ever appears.

Source files
------------

// File: rtl/wb_merge.sv
// wb_merge: shares the register-file write port between the W stage (always wins)
// and a FIFO of multi-cycle results. Define WB_MERGE_TRACE_EN for a per-write trace line.
module wb_merge #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   w_valid,
  input  logic [ADDR_W-1:0]      w_adr,
  input  logic [DATA_W-1:0]      w_data,
  input  logic [31:0]            w_pc,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [ADDR_W-1:0]      s_adr,
  input  logic [DATA_W-1:0]      s_data,
  input  logic [31:0]            s_pc,
  output logic                   regw_enable,
  output logic [ADDR_W-1:0]      regw_adr,
  output logic [DATA_W-1:0]      reg_write,
  input  logic [ADDR_W-1:0]      fwd_adr,
  output logic                   fwd_hit,
  output logic [DATA_W-1:0]      fwd_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] r_adr  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [31:0]       r_pc   [DEPTH];
  logic [DEPTH-1:0]  r_live;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              r_regwEnable;
  logic [ADDR_W-1:0] r_regwAdr;
  logic [DATA_W-1:0] r_regWrite;

  logic              w_push;
  logic              w_wSel;
  logic              w_pop;
  logic              w_popSel;
  logic              w_selValid;
  logic [ADDR_W-1:0] w_selAdr;
  logic [DATA_W-1:0] w_selData;
  logic [31:0]       w_selPc;
  logic              w_fwdHit;
  logic [DATA_W-1:0] w_fwdData;

  assign s_ready     = (r_count < FULL_CNT);
  assign count       = r_count;
  assign regw_enable = r_regwEnable;
  assign regw_adr    = r_regwAdr;
  assign reg_write   = r_regWrite;
  assign fwd_hit     = w_fwdHit;
  assign fwd_data    = w_fwdData;

  // A $0 write from W is treated as an idle slot so the FIFO can drain.
  assign w_push   = s_valid && s_ready;
  assign w_wSel   = w_valid && (w_adr != '0);
  assign w_pop    = !w_wSel && (r_count != '0);
  assign w_popSel = w_pop && r_live[r_head] && (r_adr[r_head] != '0);

  always_comb begin
    w_selValid = 1'b0;
    w_selAdr   = '0;
    w_selData  = '0;
    w_selPc    = '0;
    if (w_wSel) begin
      w_selValid = 1'b1;
      w_selAdr   = w_adr;
      w_selData  = w_data;
      w_selPc    = w_pc;
    end else if (w_popSel) begin
      w_selValid = 1'b1;
      w_selAdr   = r_adr[r_head];
      w_selData  = r_data[r_head];
      w_selPc    = r_pc[r_head];
    end
  end

  // Walk oldest to youngest so the last live match left standing is the youngest.
  always_comb begin : fwdSearch
    logic [PTR_W-1:0] idx;
    w_fwdHit  = 1'b0;
    w_fwdData = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = r_head + PTR_W'(k);
      if ((CNT_W'(k) < r_count) && r_live[idx] && (fwd_adr != '0) &&
          (r_adr[idx] == fwd_adr)) begin
        w_fwdHit  = 1'b1;
        w_fwdData = r_data[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Later assignments override earlier ones: a same-cycle push stays live even if W hits its address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_live <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wSel && (r_adr[i] == w_adr)) begin
          r_live[i] <= 1'b0;
        end
      end
      if (w_pop) begin
        r_live[r_head] <= 1'b0;
      end
      if (w_push) begin
        r_live[r_tail] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_adr[r_tail]  <= s_adr;
      r_data[r_tail] <= s_data;
      r_pc[r_tail]   <= s_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_regwEnable <= 1'b0;
      r_regwAdr    <= '0;
      r_regWrite   <= '0;
    end else begin
      r_regwEnable <= w_selValid;
      r_regwAdr    <= w_selAdr;
      r_regWrite   <= w_selData;
    end
  end

`ifdef WB_MERGE_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && w_selValid) begin
      $display("@%h: $%d <= %h", w_selPc, w_selAdr, w_selData);
    end
  end
`else
  logic w_unusedPc;
  assign w_unusedPc = ^w_selPc;
`endif

endmodule
